// File: rtl/mac_ctrl_pkg.sv
// rtl/mac_ctrl_pkg.sv - shared state encoding and geometry helpers for the MAC sequencer
package mac_ctrl_pkg;

  localparam int IMG_W_DEF = 8;
  localparam int K_DEF     = 3;

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, EMIT, FIN} state_t;

  // Output feature-map width of a valid-mode convolution
  function automatic int out_w(input int img_w, input int k);
    return img_w - k + 1;
  endfunction

  // Number of taps in one kernel window
  function automatic int kk(input int k);
    return k * k;
  endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// rtl/mac_seq_ctrl_if.sv - control, MAC/memory and result port bundle for mac_seq_ctrl
interface mac_seq_ctrl_if #(
  parameter int PADDR_W = 6,
  parameter int WADDR_W = 4,
  parameter int ACC_W   = 12,
  parameter int OADDR_W = 6
);
  logic               start;
  logic               abort;
  logic               busy;
  logic               done;
  logic [PADDR_W-1:0] pix_addr;
  logic [WADDR_W-1:0] wgt_addr;
  logic               mac_clr;
  logic               mac_en;
  logic [ACC_W-1:0]   mac_result;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_data;
  logic [OADDR_W-1:0] out_addr;

  modport master (
    input  start, abort, mac_result, out_ready,
    output busy, done, pix_addr, wgt_addr, mac_clr, mac_en, out_valid, out_data, out_addr
  );

  modport slave (
    output start, abort, mac_result, out_ready,
    input  busy, done, pix_addr, wgt_addr, mac_clr, mac_en, out_valid, out_data, out_addr
  );
endinterface

// File: rtl/win_counter.sv
// rtl/win_counter.sv - nested kernel-offset (kr/kc) and output-position (row/col) counters
module win_counter #(
  parameter int K     = 3,
  parameter int OUT_W = 6,
  parameter int KC_W  = 2,
  parameter int POS_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_k,
  input  logic             step_k,
  input  logic             clr_pos,
  input  logic             step_pos,
  output logic [KC_W-1:0]  kr,
  output logic [KC_W-1:0]  kc,
  output logic [POS_W-1:0] row,
  output logic [POS_W-1:0] col,
  output logic             k_last,
  output logic             pos_last
);
  localparam logic [KC_W-1:0]  K_MAX = KC_W'(K - 1);
  localparam logic [POS_W-1:0] P_MAX = POS_W'(OUT_W - 1);

  // Kernel tap counter: kc runs fastest, kr advances when kc wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kr <= '0;
      kc <= '0;
    end else if (clr_k) begin
      kr <= '0;
      kc <= '0;
    end else if (step_k) begin
      if (kc == K_MAX) begin
        kc <= '0;
        kr <= (kr == K_MAX) ? '0 : kr + 1'b1;
      end else begin
        kc <= kc + 1'b1;
      end
    end
  end

  // Output position counter: col runs fastest, row advances when col wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clr_pos) begin
      row <= '0;
      col <= '0;
    end else if (step_pos) begin
      if (col == P_MAX) begin
        col <= '0;
        row <= (row == P_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign k_last   = (kr == K_MAX) && (kc == K_MAX);
  assign pos_last = (row == P_MAX) && (col == P_MAX);

endmodule

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - KxK valid-mode convolution sequencer for one MAC; option MAC_CTRL_SAT_EN
module mac_seq_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int K       = K_DEF,
  parameter int ACC_W   = 12,
  parameter int PADDR_W = 6,
  parameter int WADDR_W = 4,
  parameter int OADDR_W = 6
) (
  input  logic clk,
  input  logic rst,
  mac_seq_ctrl_if.master bus
);
  localparam int OUT_W = out_w(IMG_W, K);
  localparam int KC_W  = $clog2(K + 1);
  localparam int POS_W = $clog2(OUT_W + 1);

  state_t           state, state_next;
  logic             clr_k, step_k, clr_pos, step_pos;
  logic [KC_W-1:0]  kr, kc;
  logic [POS_W-1:0] row, col;
  logic             k_last, pos_last;
  logic [ACC_W-1:0] result_fmt;

  win_counter #(.K(K), .OUT_W(OUT_W), .KC_W(KC_W), .POS_W(POS_W)) u_win (
    .clk      (clk),
    .rst      (rst),
    .clr_k    (clr_k),
    .step_k   (step_k),
    .clr_pos  (clr_pos),
    .step_pos (step_pos),
    .kr       (kr),
    .kc       (kc),
    .row      (row),
    .col      (col),
    .k_last   (k_last),
    .pos_last (pos_last)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: abort overrides every transition out of a busy state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CLEAR;
      CLEAR:   state_next = bus.abort ? IDLE : ACCUM;
      ACCUM:   if (bus.abort) state_next = IDLE;
               else if (k_last) state_next = EMIT;
      EMIT:    if (bus.abort) state_next = IDLE;
               else if (bus.out_ready) state_next = pos_last ? FIN : CLEAR;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef MAC_CTRL_SAT_EN
  assign result_fmt = (bus.mac_result > ACC_W'(255)) ? ACC_W'(255) : bus.mac_result;
`else
  assign result_fmt = bus.mac_result;
`endif

  // Outputs and counter commands decoded from the state
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.done      = (state == FIN);
    bus.mac_clr   = (state == CLEAR);
    bus.mac_en    = (state == ACCUM);
    bus.out_valid = (state == EMIT);
    bus.out_data  = (state == EMIT) ? result_fmt : '0;
    clr_pos       = (state == IDLE) && bus.start;
    clr_k         = (state == CLEAR);
    step_k        = (state == ACCUM) && !bus.abort;
    step_pos      = (state == EMIT) && bus.out_ready && !bus.abort && !pos_last;
  end

  // Address arithmetic straight from the counters (memories read asynchronously)
  assign bus.pix_addr = PADDR_W'((int'(row) + int'(kr)) * IMG_W + int'(col) + int'(kc));
  assign bus.wgt_addr = WADDR_W'(int'(kr) * K + int'(kc));
  assign bus.out_addr = OADDR_W'(int'(row) * OUT_W + int'(col));

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - self-checking bench for mac_seq_ctrl with behavioural MAC and memories
module tb_mac_seq_ctrl;
  localparam int IMG_W = 8;
  localparam int K     = 3;
  localparam int OUT_W = 6;
  localparam int NOUT  = OUT_W * OUT_W;
`ifdef MAC_CTRL_SAT_EN
  localparam int SAT_FIRST = 255;
`else
  localparam int SAT_FIRST = 2295;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_seq_ctrl_if bus_if ();
  mac_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus_if));

  logic [7:0]  pix_mem [64];
  logic [7:0]  wgt_mem [16];
  logic [11:0] acc = '0;
  assign bus_if.mac_result = acc;

  // MAC unit: clear or accumulate pixel*weight from the async-read memories
  always @(posedge clk) begin
    if (bus_if.mac_clr) acc <= '0;
    else if (bus_if.mac_en)
      acc <= acc + ({4'b0, pix_mem[bus_if.pix_addr]} * {4'b0, wgt_mem[bus_if.wgt_addr]});
  end

  int errors = 0;
  int checks = 0;
  int first_pix [9];
  int last_start = -1;

  typedef struct {
    int pix_val;
    int wgt_val;
    int mode;
    int exp_first;
    int exp_done;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int expect_out(input int o);
    int r = o / OUT_W;
    int c = o % OUT_W;
    int sum = 0;
    for (int a = 0; a < K; a++)
      for (int b = 0; b < K; b++)
        sum += int'(pix_mem[(r + a) * IMG_W + c + b]) * int'(wgt_mem[a * K + b]);
`ifdef MAC_CTRL_SAT_EN
    if (sum > 255) sum = 255;
`endif
    return sum;
  endfunction

  task automatic fill(input int pv, input int wv);
    for (int i = 0; i < 64; i++) pix_mem[i] = (pv < 0) ? 8'($urandom_range(0, 255)) : 8'(pv);
    for (int i = 0; i < 16; i++) wgt_mem[i] = (wv < 0) ? 8'($urandom_range(0, 1)) : 8'(wv);
  endtask

  task automatic start_pulse(input logic rdy);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.out_ready = rdy;
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  // mode 0: ready always, 1: 5-cycle stall at output 7, 2: random ready
  task automatic run_pass(input int mode, output int done_cyc, output int first_data, output int stalls);
    int o, s, stall_left, done_cnt, data_err, order_err, addr_err, stab_err, ctl_err;
    logic hold, r;
    logic [11:0] pd;
    logic [5:0] pa;
    o = 0; s = 0; stall_left = 5; done_cnt = 0;
    data_err = 0; order_err = 0; addr_err = 0; stab_err = 0; ctl_err = 0;
    hold = 1'b0; pd = '0; pa = '0; r = 1'b0;
    done_cyc = -1; first_data = -1; stalls = 0;
    start_pulse(mode == 0);
    for (int cyc = 1; cyc < 3000; cyc++) begin
      if (bus_if.mac_clr) s = 0;
      if (bus_if.mac_en) begin
        if (int'(bus_if.pix_addr) != (o / OUT_W + s / K) * IMG_W + o % OUT_W + s % K) addr_err++;
        if (int'(bus_if.wgt_addr) != s) addr_err++;
        if (o == 0 && s < 9) first_pix[s] = int'(bus_if.pix_addr);
        if (o == NOUT - 1 && s == 0) last_start = int'(bus_if.pix_addr);
        s++;
      end
      if (bus_if.out_valid) begin
        if (!hold && s != K * K) ctl_err++;
        if (bus_if.mac_en || bus_if.mac_clr) ctl_err++;
        if (hold && (bus_if.out_data !== pd || bus_if.out_addr !== pa)) stab_err++;
        if (int'(bus_if.out_data) != expect_out(o)) data_err++;
        if (int'(bus_if.out_addr) != o) order_err++;
        if (o == 0) first_data = int'(bus_if.out_data);
        case (mode)
          0: r = 1'b1;
          1: begin
            r = !(o == 7 && stall_left > 0);
            if (!r) stall_left--;
          end
          default: r = ($urandom_range(0, 2) != 0);
        endcase
        bus_if.out_ready = r;
        hold = !r;
        pd = bus_if.out_data;
        pa = bus_if.out_addr;
        if (r) o++;
        else stalls++;
      end else begin
        hold = 1'b0;
      end
      if (bus_if.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc > done_cyc) break;
      @(negedge clk);
    end
    check("pass_finished", done_cyc >= 0, 1);
    check("out_count", o, NOUT);
    check("out_data_vs_model", data_err, 0);
    check("out_addr_order", order_err, 0);
    check("addr_trace", addr_err, 0);
    check("emit_stability", stab_err, 0);
    check("emit_ctrl", ctl_err, 0);
    check("done_pulse_width", done_cnt, 1);
    check("idle_after_done", bus_if.busy, 0);
  endtask

  int dc, fd, st, hs, found, dn, bz;
  int exp_pix [9];

  initial begin
    vecs[0] = '{1, 1, 0, 9, 397};
    vecs[1] = '{255, 1, 0, SAT_FIRST, 397};
    vecs[2] = '{2, 3, 1, 54, 402};
    vecs[3] = '{-1, -1, 2, -1, -1};
    vecs[4] = '{-1, -1, 2, -1, -1};
    exp_pix = '{0, 1, 2, 8, 9, 10, 16, 17, 18};

    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    bus_if.out_ready = 1'b0;
    fill(1, 1);
    repeat (2) @(negedge clk);
    check("reset_ctrl", {bus_if.busy, bus_if.done, bus_if.mac_clr, bus_if.mac_en, bus_if.out_valid}, 0);
    check("reset_addr", {bus_if.pix_addr, bus_if.wgt_addr, bus_if.out_addr}, 0);
    check("reset_data", bus_if.out_data, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      fill(vecs[i].pix_val, vecs[i].wgt_val);
      run_pass(vecs[i].mode, dc, fd, st);
      if (vecs[i].exp_first >= 0) check("first_data", fd, vecs[i].exp_first);
      check("done_cycle", dc, (vecs[i].exp_done >= 0) ? vecs[i].exp_done : 397 + st);
    end

    for (int s = 0; s < 9; s++) check("first_window_pix", first_pix[s], exp_pix[s]);
    check("last_window_start", last_start, 45);

    // abort in ACCUM of output 3
    fill(1, 1);
    start_pulse(1'b1);
    hs = 0; found = 0;
    for (int n = 0; n < 200; n++) begin
      if (bus_if.out_valid) hs++;
      else if (hs == 3 && bus_if.mac_en) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("abort_point_reached", found, 1);
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.abort = 1'b0;
    check("abort_accum_idle", {bus_if.busy, bus_if.out_valid, bus_if.mac_en, bus_if.mac_clr}, 0);
    dn = 0; bz = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.done) dn++;
      if (bus_if.busy) bz++;
    end
    check("abort_no_done", dn, 0);
    check("abort_stays_idle", bz, 0);

    // abort coinciding with an EMIT handshake
    start_pulse(1'b1);
    found = 0;
    for (int n = 0; n < 50; n++) begin
      if (bus_if.out_valid) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("emit_reached", found, 1);
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.abort = 1'b0;
    check("abort_emit_idle", bus_if.busy, 0);
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus_if.done) dn++;
    end
    check("abort_emit_no_done", dn, 0);

    // restart after abort begins again at output 0
    run_pass(0, dc, fd, st);
    check("restart_done_cycle", dc, 397);
    check("restart_first_data", fd, 9);

    // start ignored while busy, then async reset mid-EMIT
    start_pulse(1'b1);
    found = 0;
    for (int n = 0; n < 200; n++) begin
      if (bus_if.out_valid && bus_if.out_addr == 6'd7) begin
        bus_if.out_ready = 1'b0;
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("emit7_reached", found, 1);
    @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    check("start_ignored_busy", {bus_if.busy, bus_if.out_valid, bus_if.out_addr}, {2'b11, 6'd7});
    check("emit7_pix_addr", bus_if.pix_addr, 9);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ctrl", {bus_if.busy, bus_if.done, bus_if.mac_clr, bus_if.mac_en, bus_if.out_valid}, 0);
    check("async_rst_addr", {bus_if.pix_addr, bus_if.wgt_addr, bus_if.out_addr}, 0);
    check("async_rst_data", bus_if.out_data, 0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus_if.done) dn++;
    end
    check("rst_no_done", dn, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_rst", bus_if.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
